// File: rtl/pipe_reg_chain_pkg.sv
// rtl/pipe_reg_chain_pkg.sv - shared stage-operation decode for the pipeline register chain
package pipe_reg_chain_pkg;

    typedef enum logic [1:0] {
        OP_HOLD,
        OP_ADVANCE,
        OP_CLEAR
    } chain_op_e;

    // clr and flush share one outcome; both outrank enable.
    function automatic chain_op_e chain_op(input logic clr, input logic flush, input logic en);
        if (clr || flush) return OP_CLEAR;
        if (en) return OP_ADVANCE;
        return OP_HOLD;
    endfunction

endpackage

// File: rtl/pipe_reg_stage.sv
// rtl/pipe_reg_stage.sv - one data+valid stage of the pipeline register chain
module pipe_reg_stage
    import pipe_reg_chain_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter bit               ZERO_BUBBLE = 1'b1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             flush,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    input  logic             v_in,
    output logic [WIDTH-1:0] q,
    output logic             v_out
);

    always_ff @(posedge clk) begin
        unique case (chain_op(clr, flush, en))
            OP_CLEAR: begin
                q     <= RESET_VALUE;
                v_out <= 1'b0;
            end
            OP_ADVANCE: begin
                // Interior stages only ever see scrubbed bubbles, so scrubbing here too is harmless.
                q     <= (v_in || !ZERO_BUBBLE) ? d : RESET_VALUE;
                v_out <= v_in;
            end
            default: begin
                q     <= q;
                v_out <= v_out;
            end
        endcase
    end

endmodule

// File: rtl/pipe_reg_chain.sv
// rtl/pipe_reg_chain.sv - DEPTH-stage pipeline register with stall, flush and occupancy count
module pipe_reg_chain
    import pipe_reg_chain_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter int               DEPTH       = 2,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter bit               ZERO_BUBBLE = 1'b1
) (
    input  logic                       clk,
    input  logic                       clr,
    input  logic                       Enable,
    input  logic                       Flush,
    input  logic [WIDTH-1:0]           Data_in,
    input  logic                       Valid_in,
    output logic [WIDTH-1:0]           Data_out,
    output logic                       Valid_out,
    output logic [$clog2(DEPTH+1)-1:0] Occupancy
);

    localparam int OCC_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic             stage_v [DEPTH];
    logic [OCC_W-1:0] occ_q;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic [WIDTH-1:0] d_i;
        logic             v_i;

        if (i == 0) begin : g_head
            assign d_i = Data_in;
            assign v_i = Valid_in;
        end else begin : g_body
            assign d_i = stage_q[i-1];
            assign v_i = stage_v[i-1];
        end

        pipe_reg_stage #(
            .WIDTH       (WIDTH),
            .RESET_VALUE (RESET_VALUE),
            .ZERO_BUBBLE (ZERO_BUBBLE)
        ) u_stage (
            .clk   (clk),
            .clr   (clr),
            .flush (Flush),
            .en    (Enable),
            .d     (d_i),
            .v_in  (v_i),
            .q     (stage_q[i]),
            .v_out (stage_v[i])
        );
    end

    // Tracks the valid-bit popcount incrementally: one word may enter and one retire per advance.
    always_ff @(posedge clk) begin
        unique case (chain_op(clr, Flush, Enable))
            OP_CLEAR:   occ_q <= '0;
            OP_ADVANCE: occ_q <= occ_q + OCC_W'(Valid_in) - OCC_W'(stage_v[DEPTH-1]);
            default:    occ_q <= occ_q;
        endcase
    end

    assign Data_out  = stage_q[DEPTH-1];
    assign Valid_out = stage_v[DEPTH-1];
    assign Occupancy = occ_q;

endmodule
